move_resolver: RTL and testbench

//  Parametrised successor to the combinational move lookup. Accepts a player move over a

---
 rtl/move_resolver_if.sv | 31 +++
 rtl/move_resolver.sv | 160 ++++++++++++++++
 tb/tb_move_resolver.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/move_resolver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// move_resolver_if : request/result handshake bundle for move_resolver
// Revision: 1.0
// ---------------------------------------------------------------------------
interface move_resolver_if #(
  parameter int MOVE_W = 2,
  parameter int DMG_W  = 4
);
  logic              req_valid;
  logic [MOVE_W-1:0] req_move;
  logic              req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [MOVE_W-1:0] res_move;
  logic [DMG_W-1:0]  res_dmg;
  logic              res_hit;
  logic              res_no_pp;
  logic              res_err;

  modport master (
    output req_valid, req_move, res_ready,
    input  req_ready, res_valid, res_move, res_dmg, res_hit, res_no_pp, res_err
  );

  modport slave (
    input  req_valid, req_move, res_ready,
    output req_ready, res_valid, res_move, res_dmg, res_hit, res_no_pp, res_err
  );
endinterface
`default_nettype wire

// File: rtl/move_resolver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// move_resolver : table move lookup with PP tracking and LFSR accuracy roll
// Revision: 1.0
// ---------------------------------------------------------------------------
module move_resolver #(
  parameter int                          NUM_MOVES = 4,
  parameter int                          MOVE_W    = $clog2(NUM_MOVES),
  parameter int                          DMG_W     = 4,
  parameter int                          ACC_W     = 4,
  parameter int                          PP_W      = 4,
  parameter int                          PP_INIT   = 4,
  parameter logic [NUM_MOVES*DMG_W-1:0]  DMG_TABLE = {4'd15, 4'd10, 4'd7, 4'd3},
  parameter logic [NUM_MOVES*ACC_W-1:0]  ACC_TABLE = {4'd0, 4'd10, 4'd12, 4'd15},
  parameter logic [15:0]                 LFSR_SEED = 16'hACE1
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      pp_reload,
  output logic [NUM_MOVES*PP_W-1:0]      pp_left,
  move_resolver_if.slave                 bus
);

  localparam logic [ACC_W-1:0] C_ACC_MAX = '1;
  localparam logic [PP_W-1:0]  C_PP_INIT = PP_W'(PP_INIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROLL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [15:0]                        lfsr_q, lfsr_d;
  logic [NUM_MOVES-1:0][PP_W-1:0]     pp_q, pp_d;
  logic [MOVE_W-1:0]                  mv_q, mv_d;
  logic                               err_q, err_d;
  logic                               no_pp_q, no_pp_d;
  logic                               res_valid_q, res_valid_d;
  logic [MOVE_W-1:0]                  res_move_q, res_move_d;
  logic [DMG_W-1:0]                   res_dmg_q, res_dmg_d;
  logic                               res_hit_q, res_hit_d;
  logic                               res_no_pp_q, res_no_pp_d;
  logic                               res_err_q, res_err_d;

  logic                               w_accept;
  logic                               w_req_err;
  logic [MOVE_W-1:0]                  w_req_idx;
  logic [PP_W-1:0]                    w_req_pp;
  logic                               w_req_no_pp;
  logic [MOVE_W-1:0]                  w_mv_idx;
  logic [ACC_W-1:0]                   w_roll;
  logic [ACC_W-1:0]                   w_acc;
  logic [DMG_W-1:0]                   w_dmg;
  logic                               w_hit;

  assign w_accept  = bus.req_valid && (state_q == S_IDLE);
  assign w_req_err = int'(bus.req_move) >= NUM_MOVES;
  // Out-of-range moves are steered to entry 0 so no lookup ever leaves the tables.
  assign w_req_idx = w_req_err ? '0 : bus.req_move;
  // A coincident reload means the PP check sees the freshly restored value.
  assign w_req_pp    = pp_reload ? C_PP_INIT : pp_q[w_req_idx];
  assign w_req_no_pp = !w_req_err && (w_req_pp == '0);

  assign w_mv_idx = err_q ? '0 : mv_q;
  assign w_roll   = lfsr_q[ACC_W-1:0];
  assign w_acc    = ACC_TABLE[int'(w_mv_idx)*ACC_W +: ACC_W];
  assign w_dmg    = DMG_TABLE[int'(w_mv_idx)*DMG_W +: DMG_W];
  assign w_hit    = !err_q && !no_pp_q && ((w_acc == C_ACC_MAX) || (w_roll < w_acc));

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    pp_d        = pp_q;
    mv_d        = mv_q;
    err_d       = err_q;
    no_pp_d     = no_pp_q;
    res_valid_d = res_valid_q;
    res_move_d  = res_move_q;
    res_dmg_d   = res_dmg_q;
    res_hit_d   = res_hit_q;
    res_no_pp_d = res_no_pp_q;
    res_err_d   = res_err_q;

    if (pp_reload) begin
      pp_d = {NUM_MOVES{C_PP_INIT}};
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          mv_d    = bus.req_move;
          err_d   = w_req_err;
          no_pp_d = w_req_no_pp;
          if (!w_req_err && !w_req_no_pp) begin
            pp_d[w_req_idx] = w_req_pp - 1'b1;
          end
          state_d = S_ROLL;
        end
      end
      S_ROLL: begin
        res_move_d  = mv_q;
        res_err_d   = err_q;
        res_no_pp_d = no_pp_q;
        res_hit_d   = w_hit;
        res_dmg_d   = w_hit ? w_dmg : '0;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      pp_q        <= {NUM_MOVES{C_PP_INIT}};
      mv_q        <= '0;
      err_q       <= 1'b0;
      no_pp_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_move_q  <= '0;
      res_dmg_q   <= '0;
      res_hit_q   <= 1'b0;
      res_no_pp_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      pp_q        <= pp_d;
      mv_q        <= mv_d;
      err_q       <= err_d;
      no_pp_q     <= no_pp_d;
      res_valid_q <= res_valid_d;
      res_move_q  <= res_move_d;
      res_dmg_q   <= res_dmg_d;
      res_hit_q   <= res_hit_d;
      res_no_pp_q <= res_no_pp_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_move  = res_move_q;
  assign bus.res_dmg   = res_dmg_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_no_pp = res_no_pp_q;
  assign bus.res_err   = res_err_q;
  assign pp_left       = pp_q;

endmodule
`default_nettype wire

// File: tb/tb_move_resolver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_move_resolver : directed + randomized checks against a behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_move_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pp_reload;
  logic        pp_reload2;
  logic [15:0] pp_left;
  logic [11:0] pp_left2;

  int n_cmp = 0;
  int n_err = 0;

  move_resolver_if #(.MOVE_W(2), .DMG_W(4)) b1 ();
  move_resolver_if #(.MOVE_W(2), .DMG_W(4)) b2 ();

  move_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp_reload (pp_reload),
    .pp_left   (pp_left),
    .bus       (b1.slave)
  );

  move_resolver #(
    .NUM_MOVES (3),
    .DMG_TABLE ({4'd10, 4'd7, 4'd3}),
    .ACC_TABLE ({4'd10, 4'd12, 4'd15})
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp_reload (pp_reload2),
    .pp_left   (pp_left2),
    .bus       (b2.slave)
  );

  always #5 clk = ~clk;

  // Reference model: tables in entry order, PP counters, and the LFSR sequence.
  int dmg_m [4] = '{3, 7, 10, 15};
  int acc_m [4] = '{15, 12, 10, 0};
  int pp_m  [4];
  int taps  [4] = '{16, 14, 13, 11};
  logic [15:0] m_lfsr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else begin
      logic fb;
      fb = 1'b0;
      for (int t = 0; t < 4; t++) fb = fb ^ m_lfsr[16 - taps[t]];
      m_lfsr <= {fb, m_lfsr[15:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pp();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(pp_m[i]);
    return r;
  endfunction

  task automatic model_reload();
    for (int i = 0; i < 4; i++) pp_m[i] = 4;
  endtask

  // One full transaction on the default instance; hold = cycles res_ready stays low in DONE.
  task automatic do_req(input int mv, input bit reload, input int hold);
    bit nopp, hit, r;
    int roll, e_dmg;
    @(negedge clk);
    chk("req_ready_idle", b1.req_ready, 1);
    b1.req_valid = 1'b1;
    b1.req_move  = 2'(mv);
    pp_reload    = reload;
    @(posedge clk);
    if (reload) model_reload();
    nopp = (pp_m[mv] == 0);
    if (!nopp) pp_m[mv] = pp_m[mv] - 1;
    #1;
    pp_reload    = 1'b0;
    b1.req_valid = 1'($urandom_range(0, 1));
    b1.req_move  = 2'($urandom_range(0, 3));
    chk("roll_res_valid", b1.res_valid, 0);
    chk("roll_req_ready", b1.req_ready, 0);
    roll  = int'(m_lfsr[3:0]);
    hit   = !nopp && (acc_m[mv] == 15 || roll < acc_m[mv]);
    e_dmg = hit ? dmg_m[mv] : 0;
    @(posedge clk);
    #1;
    chk("res_valid", b1.res_valid, 1);
    chk("res_move", b1.res_move, mv);
    chk("res_dmg", b1.res_dmg, e_dmg);
    chk("res_hit", b1.res_hit, hit);
    chk("res_no_pp", b1.res_no_pp, nopp);
    chk("res_err", b1.res_err, 0);
    chk("pp_left", pp_left, exp_pp());
    for (int h = 0; h < hold; h++) begin
      r = ($urandom_range(0, 7) == 0);
      pp_reload = r;
      @(posedge clk);
      if (r) model_reload();
      #1;
      pp_reload = 1'b0;
      chk("hold_valid", b1.res_valid, 1);
      chk("hold_dmg", b1.res_dmg, e_dmg);
      chk("hold_hit", b1.res_hit, hit);
      chk("hold_no_pp", b1.res_no_pp, nopp);
      chk("hold_pp", pp_left, exp_pp());
    end
    b1.res_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.res_ready = 1'b0;
    b1.req_valid = 1'b0;
    chk("consumed_valid", b1.res_valid, 0);
    chk("consumed_pp", pp_left, exp_pp());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    pp_reload    = 1'b0;
    pp_reload2   = 1'b0;
    b1.req_valid = 1'b0;
    b1.req_move  = '0;
    b1.res_ready = 1'b0;
    b2.req_valid = 1'b0;
    b2.req_move  = '0;
    b2.res_ready = 1'b0;
    model_reload();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", b1.req_ready, 1);
    chk("rst_res_valid", b1.res_valid, 0);
    chk("rst_res_dmg", b1.res_dmg, 0);
    chk("rst_res_hit", b1.res_hit, 0);
    chk("rst_res_no_pp", b1.res_no_pp, 0);
    chk("rst_res_err", b1.res_err, 0);
    chk("rst_res_move", b1.res_move, 0);
    chk("rst_pp_left", pp_left, 16'h4444);
    chk("rst_pp_left3", pp_left2, 12'h444);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_req_ready", b1.req_ready, 1);
    chk("idle_res_valid", b1.res_valid, 0);
    chk("idle_pp_left", pp_left, 16'h4444);

    do_req(0, 1'b0, 5);
    do_req(3, 1'b0, 0);
    for (int k = 0; k < 4; k++) do_req(1, 1'b0, 1);
    do_req(1, 1'b0, 0);
    do_req(1, 1'b1, 0);

    for (int k = 0; k < 40; k++)
      do_req(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));

    // Out-of-range move on the three-entry instance.
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_move  = 2'd3;
    @(posedge clk);
    #1;
    b2.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("err_res_valid", b2.res_valid, 1);
    chk("err_res_err", b2.res_err, 1);
    chk("err_res_dmg", b2.res_dmg, 0);
    chk("err_res_hit", b2.res_hit, 0);
    chk("err_res_move", b2.res_move, 3);
    chk("err_pp_left", pp_left2, 12'h444);
    b2.res_ready = 1'b1;
    @(posedge clk);
    #1;
    b2.res_ready = 1'b0;
    chk("err_consumed", b2.res_valid, 0);

    // Async reset while both instances are in ROLL.
    @(negedge clk);
    b1.req_valid = 1'b1;
    b1.req_move  = 2'd2;
    b2.req_valid = 1'b1;
    b2.req_move  = 2'd0;
    @(posedge clk);
    #1;
    b1.req_valid = 1'b0;
    b2.req_valid = 1'b0;
    pp_m[2] = pp_m[2] > 0 ? pp_m[2] - 1 : 0;
    chk("pre_rst_pp3", pp_left2, 12'h443);
    chk("pre_rst_pp", pp_left, exp_pp());
    rst_n = 1'b0;
    #1;
    model_reload();
    chk("arst_res_valid", b1.res_valid, 0);
    chk("arst_res_valid3", b2.res_valid, 0);
    chk("arst_req_ready", b1.req_ready, 1);
    chk("arst_pp_left", pp_left, 16'h4444);
    chk("arst_pp_left3", pp_left2, 12'h444);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(2, 1'b0, 1);
    do_req(1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
